// File: rtl/lms_ctr_mem_pkg.sv
// Shared constants and types for the lms_ctr block-transfer master to the on-chip RAM.
package lms_ctr_mem_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_RUN,
    ST_RD_RUN,
    ST_RD_DRAIN,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
  } cmd_t;

endpackage

// File: rtl/lms_ctr_mem_rd_fifo.sv
// Read-return buffer between the RAM read pipe and the read stream source.
module lms_ctr_mem_rd_fifo
  import lms_ctr_mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = lms_ctr_mem_pkg::DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/lms_ctr_mem_block_master.sv
// Avalon-MM block mover: streams words into or out of the 8192x32 RAM one command at a time.
// Build option LMS_CTR_MEM_BOUNDS_CHECK_EN rejects commands that would run past the top of RAM.
module lms_ctr_mem_block_master
  import lms_ctr_mem_pkg::*;
#(
  parameter int ADDR_W        = lms_ctr_mem_pkg::ADDR_W,
  parameter int DATA_W        = lms_ctr_mem_pkg::DATA_W,
  parameter int READ_LATENCY  = 1,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(RD_FIFO_DEPTH);

  state_e            state_q, state_d;
  cmd_t              cmd_in;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              cs_q, cs_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, reject;
  logic              wr_ready_c;

  logic [READ_LATENCY-1:0] lat_q;
  logic [CNT_W-1:0]        in_flight;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [DATA_W-1:0]       fifo_rdata;
  logic [CNT_W:0]          credit;

  logic cmd_fire, oob, last_word, wr_done, rd_req, rd_acc, rd_pop;

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, len: cmd_len};
  assign cmd_ready = (state_q == ST_IDLE) & ~reset;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign last_word = (rem_q == (ADDR_W+1)'(1));

`ifdef LMS_CTR_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W+1:0] SPAN = (ADDR_W+2)'(1) << ADDR_W;
  assign oob = ({2'b00, cmd_in.addr} + {1'b0, cmd_in.len}) > SPAN;
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) in_flight = in_flight + CNT_W'(lat_q[i]);
  end

  // Reads already issued but not yet popped must all fit in the FIFO.
  assign credit  = DEPTH_V - {1'b0, fifo_count} - {1'b0, in_flight};
  assign rd_req  = (state_q == ST_RD_RUN) && (rem_q != '0) && (credit != '0);
  assign rd_acc  = rd_req & ~avm_waitrequest;
  assign wr_done = cs_q & ~avm_waitrequest;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cs_d       = cs_q;
    wdata_d    = wdata_q;
    reject     = 1'b0;
    wr_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (oob) begin
            reject = 1'b1;
          end else begin
            addr_d = cmd_in.addr;
            rem_d  = cmd_in.len;
            if (cmd_in.len == '0)  state_d = ST_FINISH;
            else if (cmd_in.write) state_d = ST_WR_RUN;
            else                   state_d = ST_RD_RUN;
          end
        end
      end
      ST_WR_RUN: begin
        // No new beat on the final completion, so the stream is never over-consumed.
        wr_ready_c = ~cs_q | (~avm_waitrequest & ~last_word);
        if (wr_done) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          cs_d   = 1'b0;
          if (last_word) state_d = ST_FINISH;
        end
        if (wr_valid && wr_ready_c) begin
          cs_d    = 1'b1;
          wdata_d = wr_data;
        end
      end
      ST_RD_RUN: begin
        if (rd_acc) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (last_word) state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: begin
        if ((in_flight == '0) && fifo_empty) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cs_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cs_q    <= cs_d;
      wdata_q <= wdata_d;
      err_q   <= reject;
    end
  end

  // One tag per accepted read; the tag leaving the last stage marks avm_readdata valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
    end else begin
      lat_q[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) lat_q[i] <= lat_q[i-1];
    end
  end

  assign rd_pop = ~fifo_empty & rd_ready;

  lms_ctr_mem_rd_fifo #(
    .DEPTH  (RD_FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (lat_q[READ_LATENCY-1]),
    .wdata_i (avm_readdata),
    .pop_i   (rd_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FINISH);
  assign err            = err_q;
  assign wr_ready       = wr_ready_c;
  assign rd_valid       = ~fifo_empty;
  assign rd_data        = fifo_rdata;
  assign avm_chipselect = cs_q | rd_req;
  assign avm_write      = cs_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_lms_ctr_mem_block_master.sv
// Scoreboarded bench for lms_ctr_mem_block_master with a RAM slave and a reference memory model.
module tb_lms_ctr_mem_block_master;

  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int WORDS = 8192;
`ifdef LMS_CTR_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          busy, done, err;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_waitrequest;

  always #5 clk = ~clk;

  lms_ctr_mem_block_master dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_exp_t;

  logic [DW-1:0] ram     [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  wr_exp_t       exp_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int n_done = 0, n_err = 0, n_cs = 0, n_rd_acc = 0, exp_err = 0;
  int wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0, last_pop_cyc = 0, last_done_cyc = 0;
  bit wait_rand = 0, rdy_rand = 0, rdy_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: registered read data gives READ_LATENCY=1.
  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] = 32'hC0DE0000 ^ 32'(i);
    forever begin
      @(posedge clk);
      if (avm_chipselect && !avm_waitrequest) begin
        if (avm_write) ram[avm_address] <= avm_writedata;
        else           avm_readdata     <= ram[avm_address];
      end
    end
  end

  initial begin
    avm_waitrequest = 1'b0;
    rd_ready        = 1'b0;
    forever begin
      @(posedge clk); #1;
      avm_waitrequest = wait_rand && ($urandom_range(0, 2) == 0);
      if (rdy_hold)      rd_ready = 1'b0;
      else if (rdy_rand) rd_ready = ($urandom_range(0, 3) != 0);
      else               rd_ready = 1'b1;
    end
  end

  // Monitor: samples mid-cycle, each handshake seen here completes at the next rising edge.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (avm_chipselect) n_cs++;
        if (avm_chipselect && !avm_waitrequest) begin
          if (avm_write) begin
            if (exp_wr_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL wr_unexpected: addr %0h data %0h, no write expected", avm_address, avm_writedata);
            end else begin
              e = exp_wr_q.pop_front();
              check("wr_addr", avm_address, e.a);
              check("wr_data", avm_writedata, e.d);
              check("wr_be", avm_byteenable, 4'hF);
            end
            if (wr_cnt == 0) first_wr_cyc = cyc;
            wr_cnt++;
            last_wr_cyc = cyc;
          end else begin
            n_rd_acc++;
          end
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: data %0h, no read data expected", rd_data);
          end else begin
            check("rd_data", rd_data, exp_rd_q.pop_front());
          end
          last_pop_cyc = cyc;
        end
        if (done) begin n_done++; last_done_cyc = cyc; end
        if (err)  n_err++;
      end
    end
  end

  task automatic issue(input bit w, input int a, input int l, output int acc);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(a); cmd_len = (AW+1)'(l);
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("cmd_accept_timeout", cmd_ready, 1'b1);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input logic [DW-1:0] wd[$], input bit gaps);
    int i = 0, t = 0;
    while (i < wd.size() && t < 5000) begin
      wr_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = wd[i];
      @(negedge clk);
      if (wr_valid && wr_ready) i++;
      t++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    check("wr_stream_timeout", i, wd.size());
  endtask

  task automatic wait_done(input int done0, input string name);
    int t = 0;
    while (n_done == done0 && t < 3000) begin @(negedge clk); t++; end
    check({name, "_done_count"}, n_done, done0 + 1);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run_cmd(input bit w, input int a, input int l, input bit gaps, input int dbase,
                         output int acc);
    logic [DW-1:0] wd[$];
    bit rej;
    int done0, err0, cs0, idx;
    rej = BOUNDS && (a + l > WORDS);
    for (int i = 0; i < l; i++) wd.push_back(dbase >= 0 ? 32'(dbase + i) : $urandom());
    if (!rej) begin
      for (int i = 0; i < l; i++) begin
        idx = (a + i) % WORDS;
        if (w) begin
          exp_wr_q.push_back('{a: AW'(idx), d: wd[i]});
          ref_mem[idx] = wd[i];
        end else begin
          exp_rd_q.push_back(ref_mem[idx]);
        end
      end
    end else begin
      exp_err++;
    end
    done0 = n_done; err0 = n_err; cs0 = n_cs; wr_cnt = 0;
    issue(w, a, l, acc);
    if (rej) begin
      repeat (4) @(negedge clk);
      check("rej_err", n_err, err0 + 1);
      check("rej_no_done", n_done, done0);
      check("rej_no_cs", n_cs, cs0);
    end else begin
      if (w) send_words(wd, gaps);
      wait_done(done0, "cmd");
      if (l == 0) begin
        check("len0_done_latency", last_done_cyc, acc + 1);
        check("len0_no_cs", n_cs, cs0);
      end
      check("wr_queue_empty", exp_wr_q.size(), 0);
      check("rd_queue_empty", exp_rd_q.size(), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, base, t, done0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'hC0DE0000 ^ 32'(i);
    #1;
    check("reset_ctrl", {cmd_ready, busy, done, err, wr_ready, rd_valid, avm_chipselect, avm_write}, 8'h00);
    check("reset_bus", {avm_address, avm_byteenable, avm_writedata}, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", cmd_ready, 1'b1);
    check("post_reset_busy", busy, 1'b0);

    // Directed write then read-back of the same block.
    run_cmd(1'b1, 'h10, 4, 1'b0, 'hA0, acc);
    check("wr4_count", wr_cnt, 4);
    check("wr4_back_to_back", last_wr_cyc - first_wr_cyc, 3);
    check("wr4_done_latency", last_done_cyc, last_wr_cyc + 1);
    for (int i = 0; i < 4; i++) check("wr4_ram", ram[16 + i], 32'hA0 + 32'(i));
    run_cmd(1'b0, 'h10, 4, 1'b0, -1, acc);
    check("rd4_done_after_pop", (last_done_cyc > last_pop_cyc) && (last_done_cyc <= last_pop_cyc + 2), 1'b1);

    // Stalled sink: issued reads must stop at the buffer capacity.
    rdy_hold = 1'b1;
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(ref_mem['h100 + i]);
    base = n_rd_acc; done0 = n_done;
    issue(1'b0, 'h100, 8, acc);
    repeat (20) @(negedge clk);
    check("stall_reads_issued", n_rd_acc - base, 4);
    check("stall_nothing_popped", exp_rd_q.size(), 8);
    rdy_hold = 1'b0;
    wait_done(done0, "stall");
    check("stall_all_delivered", exp_rd_q.size(), 0);

    // Wrap at the top of RAM, zero-length commands.
    run_cmd(1'b1, 'h1FFE, 4, 1'b0, 'h5000, acc);
    run_cmd(1'b0, 'h1FFE, 4, 1'b0, -1, acc);
    run_cmd(1'b1, 'h55, 0, 1'b0, -1, acc);
    run_cmd(1'b0, 'h1FFF, 0, 1'b0, -1, acc);
    run_cmd(1'b1, 'h1FFC, 4, 1'b0, 'h6000, acc);

    // Random waitrequest on writes, read back with random sink stalls.
    wait_rand = 1'b1;
    run_cmd(1'b1, 'h200, 10, 1'b1, -1, acc);
    check("wr_rand_wait_count", wr_cnt, 10);
    rdy_rand = 1'b1;
    run_cmd(1'b0, 'h200, 10, 1'b0, -1, acc);

    // Reset in the middle of an 8-word read.
    wait_rand = 1'b0; rdy_rand = 1'b0;
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(ref_mem['h300 + i]);
    base = n_rd_acc; t = 0;
    issue(1'b0, 'h300, 8, acc);
    while (n_rd_acc - base < 2 && t < 100) begin @(negedge clk); t++; end
    check("pre_reset_reads", (n_rd_acc - base) >= 2, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midcmd_reset_ctrl", {cmd_ready, busy, done, err, wr_ready, rd_valid, avm_chipselect, avm_write}, 8'h00);
    check("midcmd_reset_bus", {avm_address, avm_byteenable, avm_writedata}, '0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    run_cmd(1'b0, 'h300, 8, 1'b0, -1, acc);

    // Randomized command mix.
    wait_rand = 1'b1; rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, WORDS - 1)),
              int'($urandom_range(0, 12)), 1'b1, -1, acc);
    end

    repeat (4) @(negedge clk);
    check("err_pulses_total", n_err, exp_err);
    check("final_wr_queue", exp_wr_q.size(), 0);
    check("final_rd_queue", exp_rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
